ga_sequencer: RTL
=================

GA_SEQUENCER -- requirements
Module: ga_sequencer

Interface
REQ-001 Parameter NUM_GEN, default 100, sets the number of generations per run (1..2^GEN_W-1).
REQ-002 Parameter GEN_W, default 8, sets the generation counter width.
REQ-003 Parameter FIT_W, default 16, sets the fitness value width.
REQ-004 Parameter TIMEOUT, default 4096, sets the maximum cycles allowed per stage before error.
REQ-005 clk  in  1  is the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  is the asynchronous, active-low reset.
REQ-007 start  in  1  is the run request; level input, may be held for many cycles.
REQ-008 abort  in  1  requests a synchronous stop of the current run.
REQ-009 fit_target  in  FIT_W  is the early-termination fitness threshold.
REQ-010 best_fit  in  FIT_W  is the best fitness from the fitness unit; valid when fit_done is high.
REQ-011 fit_done, sel_done, cross_done, mut_done  in  1 each  are stage completion flags; each may be a pulse or a level.
REQ-012 fit_start, sel_start, cross_start, mut_start  out  1 each  are one-cycle stage start pulses.
REQ-013 pop_load  out  1  is a one-cycle pulse that commits the mutated population as the next generation.
REQ-014 gen_count  out  GEN_W  is the number of completed generations in the current run.
REQ-015 busy  out  1  is high while a run is in progress.
REQ-016 done  out  1  is high from run completion until the next accepted start.
REQ-017 error  out  1  is a sticky stage-timeout flag.
REQ-018 hit  out  1  is high when the run ended early on fit_target.
REQ-019 state  out  3  exposes the FSM state encoding for debug.

Function
REQ-020 FSM states and encodings SHALL be IDLE=0, FIT=1, SEL=2, CROSS=3, MUT=4, COMMIT=5, FINISH=6, ERR=7.
REQ-021 start SHALL be accepted only on its rising edge (registered previous value) while in IDLE, FINISH or ERR.
- Action on acceptance: clear gen_count, done, hit and error.
- Next state: FIT.
REQ-022 On entry to each of FIT/SEL/CROSS/MUT, the matching *_start output SHALL pulse high for exactly the first cycle in that state.
REQ-023 Stage done inputs SHALL be ignored in the entry cycle and sampled from the following cycle onward.
- Consequence: a level done still held from a previous stage cannot skip a stage.
REQ-024 Transitions on sampled done SHALL be FIT->SEL, SEL->CROSS, CROSS->MUT, MUT->COMMIT.
REQ-025 In FIT, if fit_done is sampled high and best_fit >= fit_target (unsigned), the FSM SHALL go to FINISH with hit=1 instead of SEL.
REQ-026 COMMIT SHALL last one cycle, pulse pop_load and increment gen_count.
- If the incremented value equals NUM_GEN: go to FINISH.
- Otherwise: go to FIT.
REQ-027 A per-stage cycle counter SHALL clear on each stage entry and increment each cycle in the stage.
- When the counter reaches TIMEOUT-1 without done, the FSM SHALL go to ERR with error=1.
- If done is sampled in that same cycle, done wins.
REQ-028 If abort is high in any state other than IDLE, FINISH or ERR, the FSM SHALL go to IDLE next cycle.
- No further start or pop_load pulses are issued.
- gen_count holds its value; done stays low.
- abort has priority over done and timeout.
REQ-029 FINISH SHALL set done=1 and hold until a new start edge is accepted.
REQ-030 ERR SHALL hold until a new start edge is accepted; error stays set.
REQ-031 busy SHALL equal 1 in states FIT through COMMIT and 0 otherwise.
REQ-032 gen_count SHALL never wrap; it saturates at NUM_GEN.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n low SHALL immediately (asynchronously) force state=IDLE.
- All outputs go to 0, including gen_count.
- The start edge register and the stage counter are cleared.
REQ-035 Reset asserted mid-run SHALL abandon the run with no pulses after release.
- A start already held high across reset release SHALL NOT be taken as an edge; start must return low and rise again.

Verification
REQ-036 Nominal run: NUM_GEN=3, each done returned 2 cycles after its start, best_fit < fit_target.
- Required: 3 ordered FIT/SEL/CROSS/MUT pulse sequences, 3 pop_load pulses, gen_count=3, done=1, hit=0.
REQ-037 Early hit: best_fit=0x0100, fit_target=0x0100 at the second fit_done.
- Required: FINISH after gen_count=1, hit=1, no sel_start in that generation.
REQ-038 Timeout: TIMEOUT=16, sel_done never asserted.
- Required: ERR 16 cycles after sel_start, error=1, busy=0.
- Then a new start edge clears error and restarts at FIT.
REQ-039 Level done: all done inputs tied high.
- Required: each stage still occupies at least 2 cycles and all four start pulses appear per generation.
REQ-040 Abort and reset: abort in CROSS -> IDLE next cycle, gen_count held, no mut_start.
- rst_n low during MUT with start held high -> all outputs 0; no run starts until start falls and rises again.

Source files
------------

// File: rtl/ga_sequencer.sv
`timescale 1ns/1ps
// ga_sequencer: run controller for a genetic-algorithm datapath.
// Sequences FIT -> SEL -> CROSS -> MUT -> COMMIT per generation for NUM_GEN
//   generations, with early exit on fit_target, abort and per-stage timeout.
// Latency: start edge -> fit_start one cycle later; each stage lasts >= 2 cycles.
// Backpressure: stages hold until their done flag (pulse or level) is sampled.
// Ports: clk/rst_n; start/abort run control; fit_target/best_fit fitness compare;
//   *_done stage completion inputs; *_start/pop_load one-cycle pulses;
//   gen_count/busy/done/error/hit status; state debug view. All outputs registered.
module ga_sequencer #(
  parameter int NUM_GEN = 100,
  parameter int GEN_W   = 8,
  parameter int FIT_W   = 16,
  parameter int TIMEOUT = 4096   // must be >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [FIT_W-1:0] fit_target,
  input  logic [FIT_W-1:0] best_fit,
  input  logic             fit_done,
  input  logic             sel_done,
  input  logic             cross_done,
  input  logic             mut_done,
  output logic             fit_start,
  output logic             sel_start,
  output logic             cross_start,
  output logic             mut_start,
  output logic             pop_load,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             hit,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIT    = 3'd1,
    SEL    = 3'd2,
    CROSS  = 3'd3,
    MUT    = 3'd4,
    COMMIT = 3'd5,
    FINISH = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GEN_W-1:0] GEN_LAST = GEN_W'(NUM_GEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             start_low_q;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             fit_start_q, fit_start_d;
  logic             sel_start_q, sel_start_d;
  logic             cross_start_q, cross_start_d;
  logic             mut_start_q, mut_start_d;
  logic             pop_load_q, pop_load_d;

  logic start_edge;
  logic stg_done;
  logic stg_taken;

  // start_low_q clears on reset, so a start held high through reset release
  // must drop and rise again before it counts as an edge.
  assign start_edge = start & start_low_q;

  always_comb begin
    stg_done = 1'b0;
    case (state_q)
      FIT:     stg_done = fit_done;
      SEL:     stg_done = sel_done;
      CROSS:   stg_done = cross_done;
      MUT:     stg_done = mut_done;
      default: stg_done = 1'b0;
    endcase
  end

  // cnt_q is zero only in a stage's entry cycle, so it doubles as the
  // "ignore done" qualifier: a level done left over from the previous stage
  // cannot skip this one.
  assign stg_taken = stg_done && (cnt_q != '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    gen_d         = gen_q;
    done_d        = done_q;
    hit_d         = hit_q;
    err_d         = err_q;
    fit_start_d   = 1'b0;
    sel_start_d   = 1'b0;
    cross_start_d = 1'b0;
    mut_start_d   = 1'b0;
    pop_load_d    = 1'b0;

    case (state_q)
      IDLE, FINISH, ERR: begin
        if (start_edge) begin
          gen_d       = '0;
          done_d      = 1'b0;
          hit_d       = 1'b0;
          err_d       = 1'b0;
          state_d     = FIT;
          fit_start_d = 1'b1;
        end
      end

      FIT, SEL, CROSS, MUT: begin
        cnt_d = cnt_q + 1'b1;
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (stg_taken) begin
          cnt_d = '0;
          case (state_q)
            FIT: begin
              if (best_fit >= fit_target) begin
                state_d = FINISH;
                hit_d   = 1'b1;
                done_d  = 1'b1;
              end else begin
                state_d     = SEL;
                sel_start_d = 1'b1;
              end
            end
            SEL: begin
              state_d       = CROSS;
              cross_start_d = 1'b1;
            end
            CROSS: begin
              state_d     = MUT;
              mut_start_d = 1'b1;
            end
            default: begin
              // Generation count advances together with the pop_load pulse so
              // an abort during COMMIT still reports the committed generation.
              state_d    = COMMIT;
              pop_load_d = 1'b1;
              gen_d      = (gen_q == GEN_LAST) ? gen_q : gen_q + 1'b1;
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end

      COMMIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gen_q == GEN_LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d     = FIT;
          fit_start_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d inside {FIT, SEL, CROSS, MUT, COMMIT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gen_q         <= '0;
      start_low_q   <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      fit_start_q   <= 1'b0;
      sel_start_q   <= 1'b0;
      cross_start_q <= 1'b0;
      mut_start_q   <= 1'b0;
      pop_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gen_q         <= gen_d;
      start_low_q   <= ~start;
      done_q        <= done_d;
      hit_q         <= hit_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      fit_start_q   <= fit_start_d;
      sel_start_q   <= sel_start_d;
      cross_start_q <= cross_start_d;
      mut_start_q   <= mut_start_d;
      pop_load_q    <= pop_load_d;
    end
  end

  assign fit_start   = fit_start_q;
  assign sel_start   = sel_start_q;
  assign cross_start = cross_start_q;
  assign mut_start   = mut_start_q;
  assign pop_load    = pop_load_q;
  assign gen_count   = gen_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign hit         = hit_q;
  assign state       = state_q;

endmodule
